// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register map, status bit layout and the serial FSM state encoding.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR   = 32'hFFFF_FF00;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_FF04;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an explicit count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU-store driven 8N1 UART transmitter with a small byte FIFO.
// Status readable at STAT_ADDR; overflow flag is sticky until cleared.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        ovf;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  dout;
    logic        tx_wr;
    logic        stat_wr;
    logic        push;
    logic        ovf_set;
    logic        ovf_clr;

    assign tx_wr   = mem_write && (data_adr == TX_ADDR);
    assign stat_wr = mem_write && (data_adr == STAT_ADDR);
    // Uses pre-edge full, so a same-cycle pop never frees a slot.
    assign push    = tx_wr && !full;
    assign ovf_set = tx_wr && full;
    assign ovf_clr = stat_wr && write_data[0];
    assign busy    = !empty || (state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (write_data[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = dout;
                    cnt_n   = BIT_LAST;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    idx_n   = '0;
                    cnt_n   = BIT_LAST;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_n = shreg >> 1;
                    cnt_n   = BIT_LAST;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = dout;
                        cnt_n   = BIT_LAST;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        read_data = '0;
        if (data_adr == STAT_ADDR) begin
            read_data[STAT_OVF]   = ovf;
            read_data[STAT_FULL]  = full;
            read_data[STAT_EMPTY] = empty;
            read_data[STAT_BUSY]  = busy;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_uart_tx;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic idle_bus();
        mem_write  = 1'b0;
        data_adr   = 32'h0;
        write_data = 32'h0;
    endtask

    task automatic put(input logic [31:0] adr, input logic [31:0] dat);
        mem_write  = 1'b1;
        data_adr   = adr;
        write_data = dat;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic send_frames(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int n);
        logic [7:0] bs [3];
        bs = '{b0, b1, b2};
        put(TX_ADDR, {24'h0, b0});
        for (int i = 0; i < n * 40; i++) begin
            if (i < n - 1) begin
                mem_write  = 1'b1;
                data_adr   = TX_ADDR;
                write_data = {24'h0, bs[i+1]};
            end else begin
                idle_bus();
            end
            @(negedge clk);
            check($sformatf("tx f%0d b%0d", i / 40, (i % 40) / 4),
                  {31'h0, tx},
                  {31'h0, frame_bit(bs[i/40], (i % 40) / 4)});
        end
        check("busy last stop", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("busy after frames", {31'h0, busy}, 32'h0);
        check("tx after frames", {31'h0, tx}, 32'h1);
    endtask

    task automatic quiet_for(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!tx || busy) bad = 1'b1;
        end
        check(tag, {31'h0, bad}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b0;
        idle_bus();
        data_adr = STAT_ADDR;
        #1;
        check("rst tx", {31'h0, tx}, 32'h1);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst stat", read_data, 32'h2);
        idle_bus();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        send_frames(8'hA5, 8'h00, 8'h00, 1);
        send_frames(8'h01, 8'h02, 8'h03, 3);

        // Overflow: one pop, four queued, sixth store dropped.
        put(TX_ADDR, 32'h10);
        c0 = cycle;
        for (int i = 1; i < 6; i++) put(TX_ADDR, 32'h10 + i);
        data_adr = STAT_ADDR;
        #1;
        check("stat ovf full", read_data, 32'hD);
        put(STAT_ADDR, 32'h1);
        data_adr = STAT_ADDR;
        #1;
        check("stat ovf clr", read_data, 32'h5);
        while (busy && (cycle - c0) < 400) @(negedge clk);
        check("five frames len", cycle - c0, 201);
        #1;
        check("stat drained", read_data, 32'h2);
        idle_bus();
        @(negedge clk);

        // Reset mid-frame with a second byte queued.
        put(TX_ADDR, 32'h00);
        put(TX_ADDR, 32'hFF);
        repeat (14) @(negedge clk);
        check("mid frame tx", {31'h0, tx}, 32'h0);
        reset = 1'b0;
        data_adr = STAT_ADDR;
        #1;
        check("abort tx", {31'h0, tx}, 32'h1);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort stat", read_data, 32'h2);
        idle_bus();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        quiet_for("no frame after rst", 60);

        // Unmapped accesses.
        put(32'h0000_0040, 32'hA5);
        data_adr = 32'h0000_0040;
        #1;
        check("rd other adr", read_data, 32'h0);
        data_adr = TX_ADDR;
        #1;
        check("rd tx adr", read_data, 32'h0);
        idle_bus();
        quiet_for("no frame other adr", 20);
        data_adr = STAT_ADDR;
        #1;
        check("stat final", read_data, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: transmit byte FIFO entries, power of two, at least 2.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_write, input, 1: CPU store strobe, taken from the processor's data-memory port.
REQ-006 The block SHALL have port data_adr, input, 32: CPU data address.
REQ-007 The block SHALL have port write_data, input, 32: CPU store data.
REQ-008 The block SHALL have port read_data, output, 32: status word for CPU loads; combinational from data_adr and state.
REQ-009 The block SHALL have port tx, output, 1: serial line; idle high.
REQ-010 The block SHALL have port busy, output, 1: high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-011 A store to TX_ADDR (32'hFFFF_FF00) SHALL push write_data[7:0] when mem_write=1 at a rising edge and the FIFO count is below FIFO_DEPTH.
REQ-012 A store to TX_ADDR with the FIFO full SHALL be dropped and SHALL set sticky flag ovf; a pop in the same cycle SHALL NOT make room for that push.
REQ-013 A store to STAT_ADDR (32'hFFFF_FF04) with write_data[0]=1 SHALL clear ovf; if an overflow happens in the same cycle, set SHALL win.
REQ-014 Stores to any other address SHALL be ignored.
REQ-015 read_data SHALL be {28'b0, ovf, full, empty, busy} when data_adr==STAT_ADDR, otherwise 32'b0.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP; a baud counter SHALL load CLKS_PER_BIT-1 on every state or bit entry and step down to 0.
REQ-017 From IDLE with the FIFO non-empty, the block SHALL pop the head byte into a shift register and enter START at the same edge; tx SHALL be 0 during START.
REQ-018 When the counter reaches 0 in START, the FSM SHALL enter DATA with bit index 0.
REQ-019 In DATA, tx SHALL equal the shift register LSB (LSB first); at counter 0 the block SHALL shift right and advance the index; after index 7 the FSM SHALL enter STOP.
REQ-020 In STOP, tx SHALL be 1; at counter 0 the FSM SHALL go to START with a pop if the FIFO is non-empty (back-to-back frames), else to IDLE.
REQ-021 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles; a byte pushed at edge N with an idle FSM SHALL drive the start bit from edge N+1.
REQ-022 The FIFO SHALL use wrap-around read/write pointers with an explicit count of width clog2(FIFO_DEPTH)+1; simultaneous push and pop when not full SHALL leave count unchanged.

Reset
REQ-023 When reset=0, the block SHALL asynchronously clear all state: FSM=IDLE, FIFO pointers and count=0, ovf=0, shift register=0, counter=0.
REQ-024 Under reset, outputs SHALL be tx=1, busy=0, and read_data = 32'h2 at STAT_ADDR.
REQ-025 Reset asserted mid-frame SHALL abort the frame and return tx high immediately; queued bytes SHALL be discarded.

Structure
REQ-026 Package mmio_pkg SHALL hold TX_ADDR, STAT_ADDR, the status bit positions, and the uart_state_t enum.
REQ-027 The FIFO SHALL be a sub-module sync_fifo, parameterised by width 8 and FIFO_DEPTH, exposing push, pop, din, dout, full, empty.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Test: store 8'hA5 to TX_ADDR -> tx pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=0 after 40 cycles.
REQ-029 Test: 3 consecutive stores 8'h01, 8'h02, 8'h03 -> 120 cycles of contiguous frames with no idle gap between stop and start bits.
REQ-030 Test: 6 stores in 6 cycles -> first byte pops, 4 more are queued, and the 6th is dropped; a load of STAT_ADDR shows ovf=1 and full=1; after a store of 32'h1 to STAT_ADDR, ovf=0.
REQ-031 Test: reset asserted at cycle 15 of a frame -> tx=1 in the same cycle; busy=0; read_data=32'h2 at STAT_ADDR.
REQ-032 Test: store to 32'h0000_0040 and a load of another address -> no frame is sent; read_data=0.
